// File: rtl/kmkz_shift_ctrl_pkg.sv
// Shared definitions for the shift sequencing controller: funct3 codes,
// the zero-register index and the in-flight slot record.
package kmkz_shift_ctrl_pkg;

  localparam logic [2:0] FUNC_SL       = 3'b001;
  localparam logic [2:0] FUNC_SR       = 3'b101;
  localparam logic [4:0] KMKZ_REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

endpackage

// File: rtl/kmkz_shift_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset, for performance counters.
module kmkz_shift_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/kmkz_shift_ctrl.sv
// Sequencing controller for the two-stage barrel shifter: one op in flight,
// RAW hazard blocking on rs1, pipeline kill and a hazard-stall counter.
module kmkz_shift_ctrl
  import kmkz_shift_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_fun_i,
  input  logic             req_arith_i,
  input  logic             req_shamt_sel_i,
  input  logic [4:0]       req_imm_shamt_i,
  input  logic [4:0]       req_rs2_val_i,
  input  logic [4:0]       req_rs1_idx_i,
  input  logic [4:0]       req_rd_i,
  output logic             sh_valid_o,
  output logic [4:0]       sh_shamt_o,
  output logic [2:0]       sh_fun_o,
  output logic             sh_sign_o,
  output logic             sh_is_shift_o,
  output logic             sh_stall_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  input  logic             kill_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  slot_t slot;
  logic  drain;
  logic  free;
  logic  hazard;
  logic  accept;

  assign drain  = slot.valid & wb_ready_i;
  assign free   = ~slot.valid | drain;
  // rs1 must wait until the in-flight result has been written back; x0 never conflicts.
  assign hazard = slot.valid & (slot.rd != KMKZ_REG_ZERO) &
                  (req_rs1_idx_i == slot.rd) & req_valid_i;

  assign req_ready_o = free & ~hazard & ~kill_i;
  assign accept      = req_valid_i & req_ready_o;

  assign sh_valid_o    = accept;
  assign sh_is_shift_o = accept;
  assign sh_shamt_o    = req_shamt_sel_i ? req_rs2_val_i : req_imm_shamt_i;
  assign sh_fun_o      = req_fun_i;
  assign sh_sign_o     = req_arith_i;
  assign sh_stall_o    = slot.valid & ~wb_ready_i;

  assign wb_valid_o = slot.valid;
  assign wb_rd_o    = slot.rd;

  // Kill wins over everything; accept may coincide with drain for back-to-back ops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot.valid <= 1'b0;
      slot.rd    <= KMKZ_REG_ZERO;
    end else if (kill_i) begin
      slot.valid <= 1'b0;
    end else if (accept) begin
      slot.valid <= 1'b1;
      slot.rd    <= req_rd_i;
    end else if (drain) begin
      slot.valid <= 1'b0;
    end
  end

  kmkz_shift_ctrl_sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (req_valid_i & hazard & ~kill_i),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_kmkz_shift_ctrl.sv
// Self-checking bench for kmkz_shift_ctrl: directed scenarios plus a
// randomized run against a queue-based model of the in-flight op.
module tb_kmkz_shift_ctrl;
  import kmkz_shift_ctrl_pkg::*;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_fun_i;
  logic             req_arith_i;
  logic             req_shamt_sel_i;
  logic [4:0]       req_imm_shamt_i;
  logic [4:0]       req_rs2_val_i;
  logic [4:0]       req_rs1_idx_i;
  logic [4:0]       req_rd_i;
  logic             sh_valid_o;
  logic [4:0]       sh_shamt_o;
  logic [2:0]       sh_fun_o;
  logic             sh_sign_o;
  logic             sh_is_shift_o;
  logic             sh_stall_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [4:0]       wb_rd_o;
  logic             kill_i;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  kmkz_shift_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_fun_i       (req_fun_i),
    .req_arith_i     (req_arith_i),
    .req_shamt_sel_i (req_shamt_sel_i),
    .req_imm_shamt_i (req_imm_shamt_i),
    .req_rs2_val_i   (req_rs2_val_i),
    .req_rs1_idx_i   (req_rs1_idx_i),
    .req_rd_i        (req_rd_i),
    .sh_valid_o      (sh_valid_o),
    .sh_shamt_o      (sh_shamt_o),
    .sh_fun_o        (sh_fun_o),
    .sh_sign_o       (sh_sign_o),
    .sh_is_shift_o   (sh_is_shift_o),
    .sh_stall_o      (sh_stall_o),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_o         (wb_rd_o),
    .kill_i          (kill_i),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Architectural shift as the shifter would perform it from its control inputs.
  function automatic logic [31:0] shift_ref(input logic [31:0] a, input logic [2:0] fun,
                                            input logic sign, input logic [4:0] sh);
    if (fun == FUNC_SL) return a << sh;
    if (sign) return 32'($signed(a) >>> sh);
    return a >> sh;
  endfunction

  // Inputs change just after the falling edge; the next rising edge samples them.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_valid_i     = 1'b0;
    req_fun_i       = FUNC_SL;
    req_arith_i     = 1'b0;
    req_shamt_sel_i = 1'b0;
    req_imm_shamt_i = 5'd0;
    req_rs2_val_i   = 5'd0;
    req_rs1_idx_i   = 5'd0;
    req_rd_i        = 5'd0;
    wb_ready_i      = 1'b1;
    kill_i          = 1'b0;
  endtask

  task automatic req(input logic [2:0] fun, input logic arith, input logic sel,
                     input logic [4:0] imm, input logic [4:0] rs2,
                     input logic [4:0] rs1_idx, input logic [4:0] rd);
    req_valid_i     = 1'b1;
    req_fun_i       = fun;
    req_arith_i     = arith;
    req_shamt_sel_i = sel;
    req_imm_shamt_i = imm;
    req_rs2_val_i   = rs2;
    req_rs1_idx_i   = rs1_idx;
    req_rd_i        = rd;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (wb_valid_o !== 1'b0) $display("FAIL reset_wb_valid got %b exp 0", wb_valid_o); else n_pass++;
    n_total++; if (sh_stall_o !== 1'b0) $display("FAIL reset_sh_stall got %b exp 0", sh_stall_o); else n_pass++;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready_o); else n_pass++;
    n_total++; if (stall_cnt_o !== '0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt_o); else n_pass++;
  endtask

  task automatic test_single();
    req(FUNC_SL, 1'b0, 1'b0, 5'd4, 5'd29, 5'd1, 5'd5);
    #1;
    n_total++; if (sh_valid_o !== 1'b1 || sh_is_shift_o !== 1'b1) $display("FAIL single_sh_valid got %b/%b exp 1/1", sh_valid_o, sh_is_shift_o); else n_pass++;
    n_total++; if (shift_ref(32'h0000_00F1, sh_fun_o, sh_sign_o, sh_shamt_o) !== 32'h0000_0F10)
      $display("FAIL single_slli_result got %h exp 00000f10", shift_ref(32'h0000_00F1, sh_fun_o, sh_sign_o, sh_shamt_o)); else n_pass++;
    n_total++; if (wb_valid_o !== 1'b0) $display("FAIL single_wb_early got %b exp 0", wb_valid_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5) $display("FAIL single_wb got %b/%0d exp 1/5", wb_valid_o, wb_rd_o); else n_pass++;
    tick(); #1;
    n_total++; if (wb_valid_o !== 1'b0) $display("FAIL single_empty got %b exp 0", wb_valid_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    req(FUNC_SR, 1'b1, 1'b0, 5'd8, 5'd30, 5'd2, 5'd10);
    #1;
    n_total++; if (shift_ref(32'h8000_0000, sh_fun_o, sh_sign_o, sh_shamt_o) !== 32'hFF80_0000)
      $display("FAIL b2b_srai_result got %h exp ff800000", shift_ref(32'h8000_0000, sh_fun_o, sh_sign_o, sh_shamt_o)); else n_pass++;
    tick();
    req(FUNC_SR, 1'b0, 1'b1, 5'd17, 5'd3, 5'd3, 5'd11);
    #1;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready_o); else n_pass++;
    n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd10) $display("FAIL b2b_first_wb got %b/%0d exp 1/10", wb_valid_o, wb_rd_o); else n_pass++;
    n_total++; if (shift_ref(32'h8000_0000, sh_fun_o, sh_sign_o, sh_shamt_o) !== 32'h1000_0000)
      $display("FAIL b2b_srl_result got %h exp 10000000", shift_ref(32'h8000_0000, sh_fun_o, sh_sign_o, sh_shamt_o)); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd11) $display("FAIL b2b_second_wb got %b/%0d exp 1/11", wb_valid_o, wb_rd_o); else n_pass++;
    tick(); #1;
    n_total++; if (wb_valid_o !== 1'b0) $display("FAIL b2b_empty got %b exp 0", wb_valid_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd12);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd2, 5'd0, 5'd1, 5'd13);
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (sh_stall_o !== 1'b1) $display("FAIL bp_stall[%0d] got %b exp 1", i, sh_stall_o); else n_pass++;
      n_total++; if (req_ready_o !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, req_ready_o); else n_pass++;
      n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd12) $display("FAIL bp_wb[%0d] got %b/%0d exp 1/12", i, wb_valid_o, wb_rd_o); else n_pass++;
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    n_total++; if (sh_stall_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL bp_release got %b/%b exp 0/1", sh_stall_o, req_ready_o); else n_pass++;
    n_total++; if (wb_rd_o !== 5'd12) $display("FAIL bp_release_rd got %0d exp 12", wb_rd_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd13) $display("FAIL bp_next_wb got %b/%0d exp 1/13", wb_valid_o, wb_rd_o); else n_pass++;
    tick();
  endtask

  task automatic test_hazard();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd7);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd7, 5'd8);
    #1;
    n_total++; if (req_ready_o !== 1'b0 || sh_valid_o !== 1'b0) $display("FAIL hz_block got %b/%b exp 0/0", req_ready_o, sh_valid_o); else n_pass++;
    tick(); #1;
    n_total++; if (stall_cnt_o !== 8'd1) $display("FAIL hz_cnt got %0d exp 1", stall_cnt_o); else n_pass++;
    n_total++; if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL hz_retry got %b/%b exp 0/1", wb_valid_o, req_ready_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd8) $display("FAIL hz_wb got %b/%0d exp 1/8", wb_valid_o, wb_rd_o); else n_pass++;
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd0);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 5'd9);
    #1;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL hz_x0_ready got %b exp 1", req_ready_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (stall_cnt_o !== 8'd1 || wb_rd_o !== 5'd9) $display("FAIL hz_x0_after got %0d/%0d exp 1/9", stall_cnt_o, wb_rd_o); else n_pass++;
    tick();
  endtask

  task automatic test_kill();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd14);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd15);
    kill_i = 1'b1;
    #1;
    n_total++; if (req_ready_o !== 1'b0 || sh_valid_o !== 1'b0) $display("FAIL kill_block got %b/%b exp 0/0", req_ready_o, sh_valid_o); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (wb_valid_o !== 1'b0) $display("FAIL kill_flush got %b exp 0", wb_valid_o); else n_pass++;
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd20);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd20, 5'd21);
    kill_i = 1'b1;
    tick(); idle(); #1;
    n_total++; if (stall_cnt_o !== 8'd1 || wb_valid_o !== 1'b0) $display("FAIL kill_hz_cnt got %0d/%b exp 1/0", stall_cnt_o, wb_valid_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] q[$];
    int         exp_cnt;
    logic       occ, hz, exp_ready;
    logic [4:0] rs1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    n_total++; if (stall_cnt_o !== '0) $display("FAIL rnd_reset_cnt got %0d exp 0", stall_cnt_o); else n_pass++;
    exp_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      occ = (q.size() != 0);
      rs1 = ($urandom_range(0, 2) == 0 && occ) ? q[0] : 5'($urandom_range(0, 31));
      req(($urandom_range(0, 1) != 0) ? FUNC_SL : FUNC_SR, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          rs1, 5'($urandom_range(0, 3)));
      req_valid_i = ($urandom_range(0, 3) != 0);
      wb_ready_i  = ($urandom_range(0, 2) != 0);
      kill_i      = ($urandom_range(0, 15) == 0);
      hz = occ && (q[0] != 5'd0) && (req_rs1_idx_i == q[0]) && req_valid_i;
      exp_ready = (!occ || wb_ready_i) && !hz && !kill_i;
      #1;
      n_total++; if (req_ready_o !== exp_ready) $display("FAIL rnd_ready[%0d] got %b exp %b", c, req_ready_o, exp_ready); else n_pass++;
      n_total++; if (sh_valid_o !== (req_valid_i && exp_ready)) $display("FAIL rnd_sh_valid[%0d] got %b exp %b", c, sh_valid_o, req_valid_i && exp_ready); else n_pass++;
      n_total++; if (sh_shamt_o !== (req_shamt_sel_i ? req_rs2_val_i : req_imm_shamt_i)) $display("FAIL rnd_shamt[%0d] got %0d", c, sh_shamt_o); else n_pass++;
      n_total++; if (wb_valid_o !== occ || (occ && wb_rd_o !== q[0])) $display("FAIL rnd_wb[%0d] got %b/%0d exp %b", c, wb_valid_o, wb_rd_o, occ); else n_pass++;
      n_total++; if (sh_stall_o !== (occ && !wb_ready_i)) $display("FAIL rnd_stall[%0d] got %b", c, sh_stall_o); else n_pass++;
      n_total++; if (int'(stall_cnt_o) !== exp_cnt) $display("FAIL rnd_cnt[%0d] got %0d exp %0d", c, stall_cnt_o, exp_cnt); else n_pass++;
      if (kill_i) begin
        q.delete();
      end else begin
        if (occ && wb_ready_i) void'(q.pop_front());
        if (req_valid_i && exp_ready) q.push_back(req_rd_i);
      end
      if (hz && !kill_i && exp_cnt < int'(CNT_MAX)) exp_cnt++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1, 5'd3);
    tick();
    req(FUNC_SL, 1'b0, 1'b0, 5'd1, 5'd0, 5'd3, 5'd4);
    wb_ready_i = 1'b0;
    repeat ((1 << CNT_W) - 2) tick();
    #1;
    n_total++; if (stall_cnt_o !== CNT_MAX - 1'b1) $display("FAIL sat_below got %0d exp %0d", stall_cnt_o, CNT_MAX - 1'b1); else n_pass++;
    tick(); #1;
    n_total++; if (stall_cnt_o !== CNT_MAX) $display("FAIL sat_reach got %0d exp %0d", stall_cnt_o, CNT_MAX); else n_pass++;
    repeat (6) tick();
    #1;
    n_total++; if (stall_cnt_o !== CNT_MAX) $display("FAIL sat_hold got %0d exp %0d", stall_cnt_o, CNT_MAX); else n_pass++;
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_hazard();
    test_kill();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
